// File: rtl/adder_tree_pkg.sv
// Shared definitions for the pipelined adder tree.
//   clog2        : ceiling log2 of a positive integer
//   tree_levels  : number of registered reduction levels for N operands
//   saturate     : clamps a 64-bit signed value into a width-bit signed or
//                  unsigned range and reports whether clamping happened.
// Accumulator widths up to MAX_ACC_W bits are supported by the 64-bit
// arithmetic used in saturate.
package adder_tree_pkg;

    localparam int MAX_ACC_W = 62;

    typedef struct packed {
        logic        sat;    // value was clamped
        logic [63:0] value;  // clamped result, low 'width' bits meaningful
    } sat_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int tree_levels(input int n);
        return clog2(n);
    endfunction

    function automatic sat_t saturate(input logic signed [63:0] value,
                                      input int                 width,
                                      input logic               is_signed);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sat_t               r;
        if (is_signed) begin
            max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
            min_v = -max_v - 64'sd1;
        end else begin
            max_v = (64'sd1 <<< width) - 64'sd1;
            min_v = 64'sd0;
        end
        r.sat   = 1'b0;
        r.value = value;
        if (value > max_v) begin
            r.sat   = 1'b1;
            r.value = max_v;
        end else if (value < min_v) begin
            r.sat   = 1'b1;
            r.value = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the reduction tree: PAIRS pairwise additions,
// each result one bit wider than its operands so nothing is lost.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   valid_i, last_i   : tags travelling with data_i
//   data_i            : 2*PAIRS operands of IN_W bits, operand k at [k*IN_W +: IN_W]
//   valid_o, last_o   : registered tags
//   data_o            : PAIRS sums of IN_W+1 bits
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int PAIRS  = 2,
    parameter bit SIGNED = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_i,
    input  logic                        last_i,
    input  logic [2*PAIRS*IN_W-1:0]     data_i,
    output logic                        valid_o,
    output logic                        last_o,
    output logic [PAIRS*(IN_W+1)-1:0]   data_o
);

    localparam int OUT_W = IN_W + 1;

    logic [PAIRS*OUT_W-1:0] sum_d;
    logic [PAIRS*OUT_W-1:0] sum_q;
    logic                   valid_q;
    logic                   last_q;
    logic [IN_W-1:0]        op_a;
    logic [IN_W-1:0]        op_b;

    // Extension bit is the operand MSB in signed mode, zero otherwise.
    always_comb begin
        sum_d = '0;
        op_a  = '0;
        op_b  = '0;
        for (int p = 0; p < PAIRS; p++) begin
            op_a = data_i[(2*p)*IN_W   +: IN_W];
            op_b = data_i[(2*p+1)*IN_W +: IN_W];
            sum_d[p*OUT_W +: OUT_W] = {SIGNED & op_a[IN_W-1], op_a}
                                    + {SIGNED & op_b[IN_W-1], op_b};
        end
    end

    // Data only loads on valid beats; it may go stale while valid_q is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_i;
            last_q  <= valid_i & last_i;
            if (valid_i) sum_q <= sum_d;
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign data_o  = sum_q;

endmodule

// File: rtl/adder_tree_pipelined.sv
// Pipelined N-operand adder tree followed by a saturating frame accumulator.
// A vector presented in cycle t appears on sum_* in cycle t+LEVELS; the
// frame total for a last-tagged vector appears one cycle after its sum.
// Valid-only streaming, no backpressure.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : operand vector valid
//   in_data      : N packed operands, operand k at [k*W +: W]
//   in_last      : last vector of a frame (qualified by in_valid)
//   sum_valid    : tree result valid
//   sum_data     : full-precision vector sum (W+clog2(N) bits)
//   frame_valid  : one-cycle pulse, frame total valid
//   frame_sum    : saturated frame total, held between pulses
//   frame_ovf    : frame saturated at least once, held between pulses
// Constraints: N >= 2, W+clog2(N) <= ACC_W <= MAX_ACC_W.
module adder_tree_pipelined
    import adder_tree_pkg::*;
#(
    parameter int N      = 4,
    parameter int W      = 8,
    parameter int ACC_W  = 16,
    parameter int SIGNED = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [N*W-1:0]           in_data,
    input  logic                     in_last,
    output logic                     sum_valid,
    output logic [W+clog2(N)-1:0]    sum_data,
    output logic                     frame_valid,
    output logic [ACC_W-1:0]         frame_sum,
    output logic                     frame_ovf
);

    localparam int LEVELS    = tree_levels(N);
    localparam int NP        = 1 << LEVELS;
    localparam int SW        = W + LEVELS;
    localparam bit IS_SIGNED = (SIGNED != 0);

    // Missing operands are zero, which is neutral in both signed and unsigned mode.
    logic [NP*W-1:0] padded;
    if (NP == N) begin : g_nopad
        assign padded = in_data;
    end else begin : g_pad
        assign padded = {{((NP-N)*W){1'b0}}, in_data};
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int IN_W  = W + l;
        localparam int PAIRS = NP >> (l + 1);

        logic [2*PAIRS*IN_W-1:0]    din;
        logic                       din_v;
        logic                       din_l;
        logic [PAIRS*(IN_W+1)-1:0]  dout;
        logic                       dout_v;
        logic                       dout_l;

        if (l == 0) begin : g_first
            assign din   = padded;
            assign din_v = in_valid;
            assign din_l = in_valid & in_last;
        end else begin : g_next
            assign din   = g_lvl[l-1].dout;
            assign din_v = g_lvl[l-1].dout_v;
            assign din_l = g_lvl[l-1].dout_l;
        end

        adder_tree_level #(
            .IN_W   (IN_W),
            .PAIRS  (PAIRS),
            .SIGNED (IS_SIGNED)
        ) u_level (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (din_v),
            .last_i  (din_l),
            .data_i  (din),
            .valid_o (dout_v),
            .last_o  (dout_l),
            .data_o  (dout)
        );
    end

    logic [SW-1:0] tree_sum;
    logic          tree_valid;
    logic          tree_last;

    assign tree_sum   = g_lvl[LEVELS-1].dout;
    assign tree_valid = g_lvl[LEVELS-1].dout_v;
    assign tree_last  = g_lvl[LEVELS-1].dout_l;

    // Frame accumulator
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   frame_sum_q, frame_sum_d;
    logic               frame_ovf_q, frame_ovf_d;
    logic               frame_valid_q, frame_valid_d;
    logic signed [63:0] acc_ext;
    logic signed [63:0] sum_ext;
    logic signed [63:0] nxt_raw;
    sat_t               nxt;

    // 64-bit headroom means the raw add itself never wraps.
    assign acc_ext = {{(64-ACC_W){IS_SIGNED & acc_q[ACC_W-1]}}, acc_q};
    assign sum_ext = {{(64-SW){IS_SIGNED & tree_sum[SW-1]}}, tree_sum};
    assign nxt_raw = acc_ext + sum_ext;
    assign nxt     = saturate(nxt_raw, ACC_W, IS_SIGNED);

    always_comb begin
        acc_d         = acc_q;
        ovf_d         = ovf_q;
        frame_sum_d   = frame_sum_q;
        frame_ovf_d   = frame_ovf_q;
        frame_valid_d = 1'b0;
        if (tree_valid) begin
            if (tree_last) begin
                // Publish and restart in the same edge so a new frame can follow immediately.
                frame_sum_d   = nxt.value[ACC_W-1:0];
                frame_ovf_d   = ovf_q | nxt.sat;
                frame_valid_d = 1'b1;
                acc_d         = '0;
                ovf_d         = 1'b0;
            end else begin
                acc_d = nxt.value[ACC_W-1:0];
                ovf_d = ovf_q | nxt.sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q         <= '0;
            ovf_q         <= 1'b0;
            frame_sum_q   <= '0;
            frame_ovf_q   <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            ovf_q         <= ovf_d;
            frame_sum_q   <= frame_sum_d;
            frame_ovf_q   <= frame_ovf_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign sum_valid   = tree_valid;
    assign sum_data    = tree_sum;
    assign frame_valid = frame_valid_q;
    assign frame_sum   = frame_sum_q;
    assign frame_ovf   = frame_ovf_q;

endmodule
